// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS sequencer: opcode/funct codes,
// state encodings (including HALT), datapath select encodings and decode classes.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // HALT sits above the 3-bit debug field so state[2:0] reads 000 there
  typedef enum logic [3:0] {
    ST_IF     = 4'b0000,
    ST_ID     = 4'b0001,
    ST_EXE_LS = 4'b0010,
    ST_MEM    = 4'b0011,
    ST_WB_LD  = 4'b0100,
    ST_EXE_BR = 4'b0101,
    ST_EXE_AL = 4'b0110,
    ST_WB_AL  = 4'b0111,
    ST_HALT   = 4'b1000
  } state_t;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JUMP = 2'd2;
  localparam logic [1:0] PC_REG  = 2'd3;

  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_OR    = 2'd3;

  typedef enum logic [3:0] {
    C_RTYPE, C_ADDI, C_ORI, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_HALT, C_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the sequencer (master) and the datapath (slave).
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             ir_we;
  logic             reg_we;
  logic [1:0]       reg_dst;
  logic [1:0]       wb_sel;
  logic             mem_rd;
  logic             mem_we;
  logic             alu_src_b;
  logic [1:0]       alu_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  logic             halted;
  logic             illegal;

  modport master (
    input  opcode, funct, zero,
    output pc_we, pc_src, ir_we, reg_we, reg_dst, wb_sel, mem_rd, mem_we,
           alu_src_b, alu_op, state, retired, halted, illegal
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_we, pc_src, ir_we, reg_we, reg_dst, wb_sel, mem_rd, mem_we,
           alu_src_b, alu_op, state, retired, halted, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: opcode + funct -> instruction class.
module mcpu_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass
);

  always_comb begin
    iclass = C_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_JR:                                 iclass = C_JR;
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: iclass = C_RTYPE;
          default:                               iclass = C_ILLEGAL;
        endcase
      end
      OP_ADDI:         iclass = C_ADDI;
      OP_ORI:          iclass = C_ORI;
      OP_LW:           iclass = C_LW;
      OP_SW:           iclass = C_SW;
      OP_BEQ, OP_BNE:  iclass = C_BR;
      OP_J:            iclass = C_J;
      OP_JAL:          iclass = C_JAL;
      OP_HALT:         iclass = C_HALT;
      default:         iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencer: state register, per-state control decode,
// retired-instruction counter and sticky illegal-opcode flag.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  multicycle_ctrl_if.master  bus
);

  state_t           st;
  iclass_t          iclass;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             br_taken;

  logic       pc_we_d, ir_we_d, reg_we_d, mem_rd_d, mem_we_d, alu_src_b_d;
  logic [1:0] pc_src_d, reg_dst_d, wb_sel_d, alu_op_d;

  mcpu_ctrl_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .iclass (iclass)
  );

  assign br_taken = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;

  always_comb begin
    pc_we_d     = 1'b0;
    pc_src_d    = PC_SEQ;
    ir_we_d     = 1'b0;
    reg_we_d    = 1'b0;
    reg_dst_d   = RD_RT;
    wb_sel_d    = WB_ALU;
    mem_rd_d    = 1'b0;
    mem_we_d    = 1'b0;
    alu_src_b_d = 1'b0;
    alu_op_d    = ALU_ADD;
    case (st)
      ST_IF: ir_we_d = 1'b1;
      ST_ID: begin
        case (iclass)
          C_J: begin
            pc_we_d  = 1'b1;
            pc_src_d = PC_JUMP;
          end
          C_JAL: begin
            pc_we_d   = 1'b1;
            pc_src_d  = PC_JUMP;
            reg_we_d  = 1'b1;
            reg_dst_d = RD_R31;
            wb_sel_d  = WB_PC4;
          end
          C_JR: begin
            pc_we_d  = 1'b1;
            pc_src_d = PC_REG;
          end
          default: ;
        endcase
      end
      // ALU controls stay valid through WB_AL so the result is still on the bus
      ST_EXE_AL, ST_WB_AL: begin
        alu_src_b_d = (iclass != C_RTYPE);
        alu_op_d    = (iclass == C_RTYPE) ? ALU_FUNCT :
                      (iclass == C_ORI)   ? ALU_OR    : ALU_ADD;
        if (st == ST_WB_AL) begin
          reg_we_d  = 1'b1;
          reg_dst_d = (iclass == C_RTYPE) ? RD_RD : RD_RT;
          pc_we_d   = 1'b1;
        end
      end
      ST_EXE_LS: alu_src_b_d = 1'b1;
      ST_MEM: begin
        if (iclass == C_LW) begin
          mem_rd_d = 1'b1;
        end else begin
          mem_we_d = 1'b1;
          pc_we_d  = 1'b1;
        end
      end
      ST_WB_LD: begin
        reg_we_d = 1'b1;
        wb_sel_d = WB_MEM;
        pc_we_d  = 1'b1;
      end
      ST_EXE_BR: begin
        alu_op_d = ALU_SUB;
        pc_we_d  = 1'b1;
        pc_src_d = br_taken ? PC_BR : PC_SEQ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st        <= ST_IF;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (pc_we_d) retired_q <= retired_q + CNT_W'(1);
      case (st)
        ST_IF: st <= ST_ID;
        ST_ID: begin
          case (iclass)
            C_RTYPE, C_ADDI, C_ORI: st <= ST_EXE_AL;
            C_LW, C_SW:             st <= ST_EXE_LS;
            C_BR:                   st <= ST_EXE_BR;
            C_J, C_JAL, C_JR:       st <= ST_IF;
            C_HALT:                 st <= ST_HALT;
            default: begin
              illegal_q <= 1'b1;
              st        <= ST_HALT;
            end
          endcase
        end
        ST_EXE_AL: st <= ST_WB_AL;
        ST_WB_AL:  st <= ST_IF;
        ST_EXE_LS: st <= ST_MEM;
        ST_MEM:    st <= (iclass == C_LW) ? ST_WB_LD : ST_IF;
        ST_WB_LD:  st <= ST_IF;
        ST_EXE_BR: st <= ST_IF;
        ST_HALT:   st <= ST_HALT;
        default:   st <= ST_IF;
      endcase
    end
  end

  // Enables are qualified by RST so an async reset kills any in-flight strobe
  assign bus.pc_we     = pc_we_d  & RST;
  assign bus.ir_we     = ir_we_d  & RST;
  assign bus.reg_we    = reg_we_d & RST;
  assign bus.mem_rd    = mem_rd_d & RST;
  assign bus.mem_we    = mem_we_d & RST;
  assign bus.pc_src    = pc_src_d;
  assign bus.reg_dst   = reg_dst_d;
  assign bus.wb_sel    = wb_sel_d;
  assign bus.alu_src_b = alu_src_b_d;
  assign bus.alu_op    = alu_op_d;
  assign bus.state     = st[2:0];
  assign bus.halted    = (st == ST_HALT);
  assign bus.illegal   = illegal_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction table, hand-written reset/halt
// sequences and randomized instructions against a per-instruction reference model.
module tb_multicycle_ctrl;

  logic CLK;
  logic RST;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(.CNT_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int ref_retired = 0;

  typedef struct {
    int cyc; int src; int rw; int dst; int wb; int mr; int mw;
    int alu; int alub; int ill; int hlt;
  } exp_t;

  typedef struct {
    logic [5:0] op; logic [5:0] fn; logic z; exp_t e;
  } vec_t;

  typedef struct {
    int cyc; int pcwe_n; int pcwe_at; int src; int rw; int dst; int wb;
    int mr; int mw; int alu; int alub; int ir0;
  } obs_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int cyc, input int src, input int rw, input int dst,
                         input int wb, input int mr, input int mw, input int alu,
                         input int alub, input int ill, input int hlt);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z;
    v.e = '{cyc, src, rw, dst, wb, mr, mw, alu, alub, ill, hlt};
    tbl.push_back(v);
  endtask

  // Instruction-level reference: what one instruction must do, from the ISA rules
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic z);
    exp_t e;
    e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    case (op)
      6'd0: begin
        if (fn == 6'b001000) begin
          e.cyc = 2; e.src = 3;
        end else if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
          e.cyc = 4; e.rw = 1; e.dst = 1; e.alu = 2;
        end else begin
          e.cyc = 2; e.ill = 1; e.hlt = 1;
        end
      end
      6'd8:  begin e.cyc = 4; e.rw = 1; e.alu = 0; e.alub = 1; end
      6'd13: begin e.cyc = 4; e.rw = 1; e.alu = 3; e.alub = 1; end
      6'd35: begin e.cyc = 5; e.rw = 1; e.wb = 1; e.mr = 1; e.alub = 1; end
      6'd43: begin e.cyc = 4; e.mw = 1; e.alub = 1; end
      6'd4:  begin e.cyc = 3; e.alu = 1; e.src = z ? 1 : 0; end
      6'd5:  begin e.cyc = 3; e.alu = 1; e.src = z ? 0 : 1; end
      6'd2:  begin e.cyc = 2; e.src = 2; end
      6'd3:  begin e.cyc = 2; e.src = 2; e.rw = 1; e.dst = 2; e.wb = 2; end
      6'd63: begin e.cyc = 2; e.hlt = 1; end
      default: begin e.cyc = 2; e.ill = 1; e.hlt = 1; end
    endcase
    return e;
  endfunction

  // Entered just after a rising edge with the FSM in IF; returns just after
  // the edge that brings it back to IF (or into HALT).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           output obs_t o);
    o = '{12, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bus.opcode = op; bus.funct = fn; bus.zero = z;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (c == 0) o.ir0 = int'(bus.ir_we);
      if (bus.pc_we)  begin o.pcwe_n++; o.src = int'(bus.pc_src); o.pcwe_at = c; end
      if (bus.reg_we) begin o.rw++; o.dst = int'(bus.reg_dst); o.wb = int'(bus.wb_sel); end
      if (bus.mem_rd) o.mr++;
      if (bus.mem_we) o.mw++;
      if (c == 2) begin o.alu = int'(bus.alu_op); o.alub = int'(bus.alu_src_b); end
      @(posedge CLK); #1;
      if (bus.state == 3'd0) begin o.cyc = c + 1; break; end
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input obs_t o);
    chk({tag, ".ir_we_if"}, o.ir0, 1);
    chk({tag, ".cycles"}, o.cyc, e.cyc);
    chk({tag, ".pc_we_cnt"}, o.pcwe_n, e.hlt ? 0 : 1);
    if (!e.hlt) begin
      chk({tag, ".pc_we_last"}, o.pcwe_at, e.cyc - 1);
      chk({tag, ".pc_src"}, o.src, e.src);
    end
    chk({tag, ".reg_we_cnt"}, o.rw, e.rw);
    if (e.rw != 0) begin
      chk({tag, ".reg_dst"}, o.dst, e.dst);
      chk({tag, ".wb_sel"}, o.wb, e.wb);
    end
    chk({tag, ".mem_rd_cnt"}, o.mr, e.mr);
    chk({tag, ".mem_we_cnt"}, o.mw, e.mw);
    if (e.cyc >= 3) begin
      chk({tag, ".alu_op"}, o.alu, e.alu);
      chk({tag, ".alu_src_b"}, o.alub, e.alub);
    end
    chk({tag, ".illegal"}, bus.illegal, e.ill);
    chk({tag, ".halted"}, bus.halted, e.hlt);
    if (!e.hlt) ref_retired++;
    chk({tag, ".retired"}, bus.retired, ref_retired);
  endtask

  task automatic do_reset(input string tag);
    #3 RST = 1'b0;
    #1;
    chk({tag, ".rst_state"}, bus.state, 0);
    chk({tag, ".rst_pc_we"}, bus.pc_we, 0);
    chk({tag, ".rst_ir_we"}, bus.ir_we, 0);
    chk({tag, ".rst_retired"}, bus.retired, 0);
    chk({tag, ".rst_illegal"}, bus.illegal, 0);
    chk({tag, ".rst_halted"}, bus.halted, 0);
    ref_retired = 0;
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  // After a halting instruction: no PC activity for 20 cycles, then reset
  task automatic halt_watch(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus.pc_we || bus.ir_we || bus.reg_we || bus.mem_we) n++;
    end
    chk({tag, ".halt_quiet"}, n, 0);
    chk({tag, ".halt_hold"}, bus.halted, 1);
    chk({tag, ".halt_retired"}, bus.retired, ref_retired);
    @(posedge CLK); #1;
    do_reset(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t o;
    exp_t e;
    int pulses;
    logic [5:0] ops [9];
    logic [5:0] fns [6];
    logic [5:0] op, fn;
    logic z;

    ops = '{6'd0, 6'd8, 6'd13, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};

    //        op         fn         z  cyc src rw dst wb mr mw alu alub ill hlt
    add_vec(6'b000000, 6'b100000, 0, 4, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0);
    add_vec(6'b000000, 6'b100010, 1, 4, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0);
    add_vec(6'b000000, 6'b100100, 0, 4, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0);
    add_vec(6'b000000, 6'b100101, 0, 4, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0);
    add_vec(6'b000000, 6'b101010, 0, 4, 0, 1, 1, 0, 0, 0, 2, 0, 0, 0);
    add_vec(6'b001000, 6'b000000, 0, 4, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add_vec(6'b001101, 6'b000000, 0, 4, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0);
    add_vec(6'b100011, 6'b000000, 0, 5, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0);
    add_vec(6'b101011, 6'b000000, 0, 4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    add_vec(6'b000100, 6'b000000, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec(6'b000100, 6'b000000, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec(6'b000101, 6'b000000, 0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec(6'b000101, 6'b000000, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec(6'b000010, 6'b000000, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(6'b000011, 6'b000000, 0, 2, 2, 1, 2, 2, 0, 0, 0, 0, 0, 0);
    add_vec(6'b000000, 6'b001000, 0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(6'b010011, 6'b000000, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add_vec(6'b000000, 6'b000111, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add_vec(6'b111111, 6'b000000, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    RST = 1'b0;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0;
    #2;
    chk("por.state", bus.state, 0);
    chk("por.pc_we", bus.pc_we, 0);
    chk("por.ir_we", bus.ir_we, 0);
    chk("por.retired", bus.retired, 0);
    chk("por.illegal", bus.illegal, 0);
    @(posedge CLK); #1;
    RST = 1'b1;

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, o);
      compare($sformatf("vec%0d", i), tbl[i].e, o);
      if (tbl[i].e.hlt != 0) halt_watch($sformatf("vec%0d", i));
    end

    // Reset in the middle of a lw: no strobes while held, fetch restarts in IF
    bus.opcode = 6'b100011; bus.funct = '0; bus.zero = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge CLK); #1; end
    chk("midrst.pre_state", bus.state, 3);
    @(negedge CLK); #2;
    RST = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.pc_we || bus.reg_we || bus.mem_we || bus.mem_rd || bus.ir_we) pulses++;
      @(posedge CLK);
    end
    chk("midrst.no_strobes", pulses, 0);
    chk("midrst.state", bus.state, 0);
    chk("midrst.retired", bus.retired, 0);
    ref_retired = 0;
    #1 RST = 1'b1;
    run_instr(6'b000000, 6'b100000, 1'b0, o);
    compare("midrst.add", model(6'b000000, 6'b100000, 1'b0), o);

    for (int k = 0; k < 60; k++) begin
      op = ops[$urandom_range(0, 8)];
      fn = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom_range(0, 63));
      z = 1'($urandom_range(0, 1));
      e = model(op, fn, z);
      run_instr(op, fn, z, o);
      compare($sformatf("rnd%0d", k), e, o);
      if (e.hlt != 0) halt_watch($sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
